// File: rtl/usb_token_rx_pkg.sv
// Shared USB receive types: PID encodings, token fields, CRC5 constants and
// the PID classification helper used by the token receiver.
package usb_token_rx_pkg;

  typedef enum logic [3:0] {
    PID_RESERVED = 4'b0000,
    PID_OUT      = 4'b0001,
    PID_ACK      = 4'b0010,
    PID_DATA0    = 4'b0011,
    PID_PING     = 4'b0100,
    PID_SOF      = 4'b0101,
    PID_NYET     = 4'b0110,
    PID_DATA2    = 4'b0111,
    PID_SPLIT    = 4'b1000,
    PID_IN       = 4'b1001,
    PID_NAK      = 4'b1010,
    PID_DATA1    = 4'b1011,
    PID_PRE_ERR  = 4'b1100,
    PID_SETUP    = 4'b1101,
    PID_STALL    = 4'b1110,
    PID_MDATA    = 4'b1111
  } pid_t;

  typedef struct packed {
    logic [4:0] crc5;
    logic [3:0] endp;
    logic [6:0] addr;
  } token_t;

  typedef struct packed {
    logic       full_speed;
    logic       addressed;
    logic [6:0] dev_addr;
  } usb_status_t;

  typedef enum logic [1:0] {
    PC_TOKEN,
    PC_DATA,
    PC_HANDSHAKE,
    PC_SPECIAL
  } pid_class_t;

  localparam logic [4:0] CRC5_INIT     = 5'b11111;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
  localparam logic [4:0] CRC5_POLY     = 5'b00101;

  // The two low PID bits select the packet class; PING/SPLIT/PRE fall in SPECIAL.
  function automatic pid_class_t pid_class(input logic [3:0] pid);
    case (pid[1:0])
      2'b01:   return PC_TOKEN;
      2'b11:   return PC_DATA;
      2'b10:   return PC_HANDSHAKE;
      default: return PC_SPECIAL;
    endcase
  endfunction

endpackage

// File: rtl/usb_token_rx_if.sv
// Byte stream from the deserializer plus decoded strobes towards the SIE.
interface usb_token_rx_if;
  import usb_token_rx_pkg::*;

  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;

  logic        tok_valid;
  pid_t        tok_pid;
  logic [3:0]  tok_endp;
  logic        sof_valid;
  logic [10:0] frame_num;
  logic        hs_valid;
  pid_t        hs_pid;
  logic        data_valid;
  pid_t        data_pid;
  logic        err_pid;
  logic        err_crc5;

  modport master (
    output rx_active, rx_valid, rx_data, rx_error,
    input  tok_valid, tok_pid, tok_endp, sof_valid, frame_num,
    input  hs_valid, hs_pid, data_valid, data_pid, err_pid, err_crc5
  );

  modport slave (
    input  rx_active, rx_valid, rx_data, rx_error,
    output tok_valid, tok_pid, tok_endp, sof_valid, frame_num,
    output hs_valid, hs_pid, data_valid, data_pid, err_pid, err_crc5
  );

endinterface

// File: rtl/usb_crc5_byte.sv
// Eight-bit-parallel USB CRC5 next state (x^5+x^2+1), bits consumed LSB first.
module usb_crc5_byte
  import usb_token_rx_pkg::*;
(
  input  logic [4:0] crc_in,
  input  logic [7:0] data,
  output logic [4:0] crc_out
);

  logic [4:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (data[i] ^ c[4]) c = {c[3:0], 1'b0} ^ CRC5_POLY;
      else                c = {c[3:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb_token_rx.sv
// USB token/PID receiver: validates PID and CRC5, filters address/endpoint and
// emits single-cycle strobes for tokens, SOF, handshakes, data starts and errors.
module usb_token_rx
  import usb_token_rx_pkg::*;
#(
  parameter int USB_FULL_SPEED = 0,
  parameter int NUM_ENDP       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] dev_addr,
  usb_token_rx_if.slave bus
);

  if (NUM_ENDP < 1 || NUM_ENDP > 16 || USB_FULL_SPEED < 0 || USB_FULL_SPEED > 1) begin : g_bad_param
    $error("usb_token_rx: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_TOK1,
    S_TOK2,
    S_EOP,
    S_DROP
  } state_t;

  state_t     state_q, state_d;
  logic       rx_active_p0;
  pid_t       pid_p0;
  logic [6:0] addr_p0;
  logic [3:0] endp_p0;
  logic [4:0] crc_p0;
  logic [4:0] crc_next;

  logic       pid_ok, endp_ok, crc_good;
  pid_class_t rx_class, held_class;
  logic       tok_stb, sof_stb, hs_stb, data_stb, perr_stb, crc_stb;

  usb_crc5_byte u_crc (
    .crc_in  (crc_p0),
    .data    (bus.rx_data),
    .crc_out (crc_next)
  );

  assign pid_ok     = (bus.rx_data[7:4] == ~bus.rx_data[3:0]);
  assign rx_class   = pid_class(bus.rx_data[3:0]);
  assign held_class = pid_class(pid_p0);
  assign endp_ok    = ({1'b0, endp_p0} < 5'(NUM_ENDP));
  assign crc_good   = (crc_p0 == CRC5_RESIDUAL);

  always_comb begin
    state_d  = state_q;
    tok_stb  = 1'b0;
    sof_stb  = 1'b0;
    hs_stb   = 1'b0;
    data_stb = 1'b0;
    perr_stb = 1'b0;
    crc_stb  = 1'b0;
    case (state_q)
      // Enter only on a fresh rising edge so an aborted packet is never resumed.
      S_IDLE: if (bus.rx_active && !rx_active_p0) state_d = S_PID;
      S_PID: begin
        if (bus.rx_error)       state_d = S_DROP;
        else if (!bus.rx_active) state_d = S_IDLE;
        else if (bus.rx_valid) begin
          if (!pid_ok) begin
            perr_stb = 1'b1;
            state_d  = S_DROP;
          end else begin
            case (rx_class)
              PC_TOKEN:     state_d = S_TOK1;
              PC_HANDSHAKE: state_d = S_EOP;
              PC_DATA: begin
                data_stb = 1'b1;
                state_d  = S_DROP;
              end
              default:      state_d = S_DROP;
            endcase
          end
        end
      end
      S_TOK1, S_TOK2: begin
        if (bus.rx_error)        state_d = S_DROP;
        else if (!bus.rx_active) state_d = S_IDLE;
        else if (bus.rx_valid)   state_d = (state_q == S_TOK1) ? S_TOK2 : S_EOP;
      end
      S_EOP: begin
        if (bus.rx_error)      state_d = S_DROP;
        else if (!bus.rx_active) begin
          state_d = S_IDLE;
          if (held_class == PC_HANDSHAKE) hs_stb = 1'b1;
          else if (!crc_good)            crc_stb = 1'b1;
          else if (pid_p0 == PID_SOF)    sof_stb = 1'b1;
          else if (addr_p0 == dev_addr && endp_ok) tok_stb = 1'b1;
        end
        else if (bus.rx_valid) state_d = S_DROP;
      end
      S_DROP: if (!bus.rx_active) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rx_active_p0   <= 1'b1;
      bus.tok_valid  <= 1'b0;
      bus.sof_valid  <= 1'b0;
      bus.hs_valid   <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.err_pid    <= 1'b0;
      bus.err_crc5   <= 1'b0;
      bus.tok_pid    <= PID_RESERVED;
      bus.tok_endp   <= 4'd0;
      bus.hs_pid     <= PID_RESERVED;
      bus.data_pid   <= PID_RESERVED;
      bus.frame_num  <= 11'd0;
    end else begin
      state_q        <= state_d;
      rx_active_p0   <= bus.rx_active;
      bus.tok_valid  <= tok_stb;
      bus.sof_valid  <= sof_stb;
      bus.hs_valid   <= hs_stb;
      bus.data_valid <= data_stb;
      bus.err_pid    <= perr_stb;
      bus.err_crc5   <= crc_stb;
      if (tok_stb) begin
        bus.tok_pid  <= pid_p0;
        bus.tok_endp <= endp_p0;
      end
      if (sof_stb)  bus.frame_num <= {endp_p0, addr_p0};
      if (hs_stb)   bus.hs_pid    <= pid_p0;
      if (data_stb) bus.data_pid  <= pid_t'(bus.rx_data[3:0]);
    end
  end

  // Packet field capture
  always_ff @(posedge clk) begin
    if (bus.rx_valid) begin
      case (state_q)
        S_PID: begin
          pid_p0 <= pid_t'(bus.rx_data[3:0]);
          crc_p0 <= CRC5_INIT;
        end
        S_TOK1: begin
          addr_p0    <= bus.rx_data[6:0];
          endp_p0[0] <= bus.rx_data[7];
          crc_p0     <= crc_next;
        end
        S_TOK2: begin
          endp_p0[3:1] <= bus.rx_data[2:0];
          crc_p0       <= crc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_token_rx.sv
// Scenario bench for usb_token_rx: expected strobes queued per packet and
// matched by a monitor, plus inline timing and reset-value checks.
module tb_usb_token_rx;
  import usb_token_rx_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] dev_addr;

  usb_token_rx_if bus();

  usb_token_rx #(.USB_FULL_SPEED(0), .NUM_ENDP(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .dev_addr (dev_addr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] K_NONE = 6'b000000;
  localparam logic [5:0] K_TOK  = 6'b100000;
  localparam logic [5:0] K_SOF  = 6'b010000;
  localparam logic [5:0] K_HS   = 6'b001000;
  localparam logic [5:0] K_DATA = 6'b000100;
  localparam logic [5:0] K_PERR = 6'b000010;
  localparam logic [5:0] K_CRC  = 6'b000001;

  typedef struct {
    logic [5:0]  kind;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  wire [5:0] stb = {bus.tok_valid, bus.sof_valid, bus.hs_valid,
                    bus.data_valid, bus.err_pid, bus.err_crc5};

  function automatic logic [10:0] obs_val(input logic [5:0] k);
    case (k)
      K_TOK:   return {3'b000, bus.tok_endp, bus.tok_pid};
      K_SOF:   return bus.frame_num;
      K_HS:    return {7'd0, bus.hs_pid};
      K_DATA:  return {7'd0, bus.data_pid};
      default: return 11'd0;
    endcase
  endfunction

  // Bit-serial reference generator: returns {byte2, byte1} of a token with its CRC5.
  function automatic logic [15:0] mk_token(input logic [6:0] addr, input logic [3:0] endp);
    logic [4:0]  c;
    logic [10:0] bits;
    logic [7:0]  b2;
    logic        fb;
    c    = 5'b11111;
    bits = {endp, addr};
    for (int i = 0; i < 11; i++) begin
      fb = bits[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    b2[2:0] = endp[3:1];
    for (int k = 0; k < 5; k++) b2[3+k] = ~c[4-k];
    return {b2, endp[0], addr};
  endfunction

  task automatic push(input logic [5:0] kind, input logic [10:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (stb != K_NONE) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL monitor_unexpected strobes=%b required=none", stb);
        end else begin
          e = sb.pop_front();
          if (e.kind !== stb || e.val !== obs_val(stb)) begin
            failures++;
            $display("FAIL monitor_event strobes=%b value=%h required strobes=%b value=%h",
                     stb, obs_val(stb), e.kind, e.val);
          end
        end
      end
    end
  endtask

  task automatic run_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int n, input logic [5:0] s_pid, input logic [5:0] s_eop,
                            input bit b2b, input string name);
    @(posedge clk); #1 bus.rx_active = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      bus.rx_data  = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1 bus.rx_valid = 1'b0;
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if (stb !== s_pid) begin
          failures++;
          $display("FAIL %s_pid_strobe got=%b required=%b", name, stb, s_pid);
        end
      end
      @(posedge clk); #1;
    end
    bus.rx_active = 1'b0;
    @(posedge clk);
    if (b2b) begin
      #1 bus.rx_active = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (stb !== s_eop) begin
      failures++;
      $display("FAIL %s_eop_strobe got=%b required=%b", name, stb, s_eop);
    end
    if (!b2b) begin
      @(negedge clk);
      checks++;
      if (stb !== K_NONE) begin
        failures++;
        $display("FAIL %s_strobe_width got=%b required=%b", name, stb, K_NONE);
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL %s_pending got=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (stb !== K_NONE || bus.tok_pid !== 4'h0 || bus.tok_endp !== 4'h0 ||
        bus.hs_pid !== 4'h0 || bus.data_pid !== 4'h0 || bus.frame_num !== 11'h000) begin
      failures++;
      $display("FAIL %s got strobes=%b tok_pid=%h tok_endp=%h hs_pid=%h data_pid=%h frame=%h required all zero",
               name, stb, bus.tok_pid, bus.tok_endp, bus.hs_pid, bus.data_pid, bus.frame_num);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_state");
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_setup();
    dev_addr = 7'd0;
    push(K_TOK, {3'b000, 4'h0, 4'hD});
    run_packet(8'h2D, 8'h00, 8'h10, 3, K_NONE, K_TOK, 1'b0, "setup");
    check_drained("setup");
  endtask

  task automatic test_crc_err();
    push(K_CRC, 11'd0);
    run_packet(8'h2D, 8'h00, 8'h11, 3, K_NONE, K_CRC, 1'b0, "crc_err");
    check_drained("crc_err");
  endtask

  task automatic test_bad_pid();
    push(K_PERR, 11'd0);
    run_packet(8'h2C, 8'h00, 8'h10, 3, K_PERR, K_NONE, 1'b0, "bad_pid");
    check_drained("bad_pid");
  endtask

  task automatic test_addr_filter();
    logic [15:0] t;
    dev_addr = 7'd5;
    t = mk_token(7'd3, 4'd0);
    run_packet(8'hE1, t[7:0], t[15:8], 3, K_NONE, K_NONE, 1'b0, "wrong_addr");
    t = mk_token(7'd5, 4'd7);
    run_packet(8'hE1, t[7:0], t[15:8], 3, K_NONE, K_NONE, 1'b0, "endp7");
    t = mk_token(7'd5, 4'd4);
    run_packet(8'hE1, t[7:0], t[15:8], 3, K_NONE, K_NONE, 1'b0, "endp4");
    t = mk_token(7'd5, 4'd0);
    push(K_TOK, {3'b000, 4'h0, 4'h9});
    run_packet(8'h69, t[7:0], t[15:8], 3, K_NONE, K_TOK, 1'b0, "in_endp0");
    t = mk_token(7'd5, 4'd3);
    push(K_TOK, {3'b000, 4'h3, 4'h1});
    run_packet(8'hE1, t[7:0], t[15:8], 3, K_NONE, K_TOK, 1'b0, "out_endp3");
    check_drained("addr_filter");
  endtask

  task automatic test_sof();
    logic [15:0] t;
    dev_addr = 7'd5;
    t = mk_token(7'h25, 4'h5);
    push(K_SOF, 11'h2A5);
    run_packet(8'hA5, t[7:0], t[15:8], 3, K_NONE, K_SOF, 1'b0, "sof");
    check_drained("sof");
  endtask

  task automatic test_handshake();
    logic [7:0] hs_bytes [4];
    hs_bytes = '{8'hD2, 8'h5A, 8'h1E, 8'h96};
    for (int i = 0; i < 4; i++) begin
      push(K_HS, {7'd0, hs_bytes[i][3:0]});
      run_packet(hs_bytes[i], 8'h00, 8'h00, 1, K_NONE, K_HS, 1'b0, "handshake");
    end
    run_packet(8'hD2, 8'h00, 8'h00, 2, K_NONE, K_NONE, 1'b0, "hs_extra_byte");
    check_drained("handshake");
  endtask

  task automatic test_data_and_special();
    push(K_DATA, {7'd0, 4'hB});
    run_packet(8'h4B, 8'h11, 8'h22, 3, K_DATA, K_NONE, 1'b0, "data1");
    run_packet(8'hB4, 8'h00, 8'h10, 3, K_NONE, K_NONE, 1'b0, "ping");
    check_drained("data_special");
  endtask

  task automatic test_short_and_error();
    dev_addr = 7'd0;
    run_packet(8'h2D, 8'h00, 8'h00, 2, K_NONE, K_NONE, 1'b0, "short");
    @(posedge clk); #1 bus.rx_active = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus.rx_data  = (i == 0) ? 8'h2D : (i == 1) ? 8'h00 : 8'h10;
      bus.rx_valid = 1'b1;
      bus.rx_error = (i == 2);
      @(posedge clk); #1 bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
      @(posedge clk); #1;
    end
    bus.rx_active = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_drained("rx_error");
  endtask

  task automatic test_reset_mid();
    dev_addr = 7'd0;
    push(K_HS, {7'd0, 4'h2});
    run_packet(8'hD2, 8'h00, 8'h00, 1, K_NONE, K_HS, 1'b0, "ack");
    @(posedge clk); #1 bus.rx_active = 1'b1;
    @(posedge clk); #1;
    bus.rx_data = 8'h2D; bus.rx_valid = 1'b1;
    @(posedge clk); #1 bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid_values");
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      bus.rx_data  = (i == 0) ? 8'h00 : 8'h10;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1 bus.rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.rx_active = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_drained("reset_mid_drop");
    push(K_TOK, {3'b000, 4'h0, 4'hD});
    run_packet(8'h2D, 8'h00, 8'h10, 3, K_NONE, K_TOK, 1'b0, "after_reset");
    check_drained("after_reset");
  endtask

  task automatic test_back_to_back();
    dev_addr = 7'd0;
    push(K_TOK, {3'b000, 4'h0, 4'hD});
    push(K_HS, {7'd0, 4'hA});
    run_packet(8'h2D, 8'h00, 8'h10, 3, K_NONE, K_TOK, 1'b1, "b2b_first");
    run_packet(8'h5A, 8'h00, 8'h00, 1, K_NONE, K_HS, 1'b0, "b2b_second");
    check_drained("back_to_back");
  endtask

  initial begin
    reset        = 1'b1;
    dev_addr     = 7'd0;
    bus.rx_active = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_error  = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_setup();
    test_crc_err();
    test_bad_pid();
    test_addr_filter();
    test_sof();
    test_handshake();
    test_data_and_special();
    test_short_and_error();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
